// File: rtl/output_switch_ctrl.sv
// output_switch_ctrl
//   Sequences a glitch-free change of the video output source:
//   blank -> wait vsync -> pulse HDMI TX reset -> flip mux -> (wait for
//   scanconverter PLL lock) -> wait vsync -> unblank.
//
// Ports
//   clk27      in   27 MHz clock, all logic on its rising edge
//   reset_n    in   asynchronous active-low reset
//   sel_req    in   requested source, 1=videogen, 0=scanconverter (level)
//   pll_lock   in   scanconverter PLL lock
//   vsync_in   in   VSYNC of the currently selected output, active-high
//   src_sel    out  applied output mux select
//   blank      out  forces DE/RGB to zero at the output mux
//   tx_reset_n out  active-low HDMI transmitter reset
//   busy       out  high while a switch sequence runs
//   done       out  one-cycle pulse at the end of a sequence
//   lock_err   out  sticky: last sequence timed out waiting for PLL lock
module output_switch_ctrl #(
  parameter int unsigned VS_TO       = 1350000,
  parameter int unsigned RST_CYCLES  = 27,
  parameter int unsigned LOCK_STABLE = 2700,
  parameter int unsigned LOCK_TO     = 2700000
) (
  input  logic clk27,
  input  logic reset_n,
  input  logic sel_req,
  input  logic pll_lock,
  input  logic vsync_in,
  output logic src_sel,
  output logic blank,
  output logic tx_reset_n,
  output logic busy,
  output logic done,
  output logic lock_err
);

  localparam int CW = 22;
  localparam logic [CW-1:0] VS_LAST   = CW'(VS_TO - 1);
  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TO - 1);

  typedef enum logic [2:0] {
    IDLE, BLANK_WAIT, TX_RST, SWITCH, LOCK_WAIT, UNBLANK_WAIT
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0]  stab_q, stab_d, stab_inc;
  logic           vs_prev_q;
  logic           target_q, target_d;
  logic           src_sel_q, src_sel_d;
  logic           blank_q, blank_d;
  logic           txrst_n_q, txrst_n_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           lock_err_q, lock_err_d;
  logic           vs_edge;

  assign vs_edge  = vsync_in & ~vs_prev_q;
  // saturating increments: counters never wrap
  assign cnt_inc  = (cnt_q  == '1) ? cnt_q  : cnt_q  + 1'b1;
  assign stab_inc = (stab_q == '1) ? stab_q : stab_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_inc;
    stab_d     = stab_q;
    target_d   = target_q;
    src_sel_d  = src_sel_q;
    blank_d    = blank_q;
    txrst_n_d  = txrst_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    lock_err_d = lock_err_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        stab_d = '0;
        if (sel_req != src_sel_q) begin
          target_d   = sel_req;
          blank_d    = 1'b1;
          busy_d     = 1'b1;
          lock_err_d = 1'b0;
          state_d    = BLANK_WAIT;
        end
      end
      BLANK_WAIT: begin
        // timeout here just means no vsync arrived; not an error
        if (vs_edge || cnt_q == VS_LAST) begin
          txrst_n_d = 1'b0;
          cnt_d     = '0;
          state_d   = TX_RST;
        end
      end
      TX_RST: begin
        // mux flip and reset release are registered on SWITCH entry so
        // tx_reset_n is low for exactly RST_CYCLES and both are valid in SWITCH
        if (cnt_q == RST_LAST) begin
          txrst_n_d = 1'b1;
          src_sel_d = target_q;
          cnt_d     = '0;
          state_d   = SWITCH;
        end
      end
      SWITCH: begin
        cnt_d   = '0;
        stab_d  = '0;
        state_d = target_q ? UNBLANK_WAIT : LOCK_WAIT;
      end
      LOCK_WAIT: begin
        stab_d = pll_lock ? stab_inc : '0;
        // lock-stable checked first so it wins a same-cycle timeout
        if (pll_lock && stab_q == STAB_LAST) begin
          cnt_d   = '0;
          stab_d  = '0;
          state_d = UNBLANK_WAIT;
        end else if (cnt_q == LOCK_LAST) begin
          // blank stays asserted: the output is not trustworthy
          lock_err_d = 1'b1;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          cnt_d      = '0;
          stab_d     = '0;
          state_d    = IDLE;
        end
      end
      UNBLANK_WAIT: begin
        if (vs_edge || cnt_q == VS_LAST) begin
          blank_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        stab_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      stab_q     <= '0;
      vs_prev_q  <= 1'b0;
      target_q   <= 1'b1;
      src_sel_q  <= 1'b1;
      blank_q    <= 1'b0;
      txrst_n_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stab_q     <= stab_d;
      vs_prev_q  <= vsync_in;
      target_q   <= target_d;
      src_sel_q  <= src_sel_d;
      blank_q    <= blank_d;
      txrst_n_q  <= txrst_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign src_sel    = src_sel_q;
  assign blank      = blank_q;
  assign tx_reset_n = txrst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign lock_err   = lock_err_q;

endmodule

// File: tb/tb_output_switch_ctrl.sv
// Bench for output_switch_ctrl with small timing parameters.
// Each expected sequence outcome is queued before the stimulus starts it;
// a negedge monitor pops one entry per done pulse and compares.
module tb_output_switch_ctrl;
  localparam int VS_TO = 100, RST_CYCLES = 4, LOCK_STABLE = 8, LOCK_TO = 200;

  logic clk27 = 1'b0, reset_n = 1'b1, sel_req = 1'b0, vsync_in = 1'b0;
  logic pll_lvl = 1'b1, pll_t = 1'b0, pll_tog = 1'b0, vs_en = 1'b1;
  logic pll_lock;
  logic src_sel, blank, tx_reset_n, busy, done, lock_err;

  assign pll_lock = pll_tog ? pll_t : pll_lvl;

  output_switch_ctrl #(.VS_TO(VS_TO), .RST_CYCLES(RST_CYCLES),
                       .LOCK_STABLE(LOCK_STABLE), .LOCK_TO(LOCK_TO)) dut (
    .clk27(clk27), .reset_n(reset_n), .sel_req(sel_req), .pll_lock(pll_lock),
    .vsync_in(vsync_in), .src_sel(src_sel), .blank(blank),
    .tx_reset_n(tx_reset_n), .busy(busy), .done(done), .lock_err(lock_err));

  always #5 clk27 = ~clk27;

  int nchk = 0, nerr = 0;
  task automatic chk(input string tag, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // lat_* = -1 means don't care; at_vs=1 means the sequence must end on a vsync edge
  typedef struct {
    string tag; int src; int blk; int err;
    int lat_busy; int lat_bw; int lat_tx; int at_vs;
  } exp_t;
  exp_t sb[$];

  task automatic push(input string tag, input int src, input int blk, input int err,
                      input int lb, input int lbw, input int ltx, input int avs);
    exp_t e;
    e.tag = tag; e.src = src; e.blk = blk; e.err = err;
    e.lat_busy = lb; e.lat_bw = lbw; e.lat_tx = ltx; e.at_vs = avs;
    sb.push_back(e);
  endtask

  // vsync: one-cycle pulse every 50 cycles; pll_t toggles every 5 cycles
  initial begin
    int vcnt = 0;
    forever begin
      @(posedge clk27); #1;
      vcnt++;
      vsync_in = vs_en && (vcnt % 50 == 0);
      if (vcnt % 5 == 0) pll_t = ~pll_t;
    end
  end

  // monitor
  int cyc = 0, t_busy = 0, t_txf = 0, t_txr = 0, txlow = 0;
  logic busy_p = 1'b0, tx_p = 1'b1, done_p = 1'b0, vs_p = 1'b0;
  always @(negedge clk27) begin : mon
    exp_t e;
    cyc++;
    if (busy && !busy_p) begin t_busy = cyc; txlow = 0; end
    if (!tx_reset_n) txlow++;
    if (!tx_reset_n && tx_p) t_txf = cyc;
    if (tx_reset_n && !tx_p) t_txr = cyc;
    if (done) begin
      chk("done_width", int'(done_p), 0);
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk({e.tag, "_src"}, int'(src_sel), e.src);
        chk({e.tag, "_blank"}, int'(blank), e.blk);
        chk({e.tag, "_lock_err"}, int'(lock_err), e.err);
        chk({e.tag, "_busy"}, int'(busy), 0);
        chk({e.tag, "_txlow"}, txlow, RST_CYCLES);
        if (e.lat_busy >= 0) chk({e.tag, "_lat_busy"}, cyc - t_busy, e.lat_busy);
        if (e.lat_bw >= 0)   chk({e.tag, "_lat_blankwait"}, t_txf - t_busy, e.lat_bw);
        if (e.lat_tx >= 0)   chk({e.tag, "_lat_tx2done"}, cyc - t_txr, e.lat_tx);
        if (e.at_vs != 0)    chk({e.tag, "_at_vsync"}, int'(vs_p), 1);
      end
    end
    busy_p = busy; tx_p = tx_reset_n; done_p = done; vs_p = vsync_in;
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk27);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    @(negedge clk27);
    while (!done && k < 1000) begin @(negedge clk27); k++; end
    if (!done) chk({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_tx(input string tag, input logic lvl);
    int k = 0;
    @(negedge clk27);
    while (tx_reset_n !== lvl && k < 1000) begin @(negedge clk27); k++; end
    if (tx_reset_n !== lvl) chk({tag, "_tx_timeout"}, 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_src"}, int'(src_sel), 1);
    chk({tag, "_blank"}, int'(blank), 0);
    chk({tag, "_txrst_n"}, int'(tx_reset_n), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_lock_err"}, int'(lock_err), 0);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    cyc_n(3);
    chk_reset_vals("rst");

    // S1: switch to scanconverter, PLL locked, vsync running
    push("s1", 0, 0, 0, -1, -1, -1, 1);
    reset_n = 1'b1;
    @(negedge clk27);
    chk("s1_blank_next", int'(blank), 1);
    chk("s1_busy_next", int'(busy), 1);
    wait_done("s1");

    // S3: no vsync, both vsync waits run to timeout (target 1: no lock wait)
    vs_en = 1'b0;
    push("s3", 1, 0, 0, VS_TO + RST_CYCLES + 1 + VS_TO, VS_TO, 1 + VS_TO, 0);
    sel_req = 1'b1;
    wait_done("s3");

    // S4: PLL never stable for 8 cycles -> lock timeout
    vs_en = 1'b1; pll_tog = 1'b1;
    push("s4", 0, 1, 1, -1, -1, 1 + LOCK_TO, 0);
    sel_req = 1'b0;
    wait_done("s4");
    cyc_n(5);
    chk("s4_blank_held", int'(blank), 1);
    chk("s4_idle_busy", int'(busy), 0);
    chk("s4_err_sticky", int'(lock_err), 1);

    // S2: to videogen with PLL unlocked; a lock wait here would time out
    pll_tog = 1'b0; pll_lvl = 1'b0;
    push("s2", 1, 0, 0, -1, -1, -1, 1);
    sel_req = 1'b1;
    @(negedge clk27);
    chk("s2_err_clr", int'(lock_err), 0);
    chk("s2_busy", int'(busy), 1);
    wait_done("s2");

    // S5: request flipped back during TX_RST; second sequence follows done
    pll_lvl = 1'b1;
    push("s5a", 0, 0, 0, -1, -1, -1, 1);
    push("s5b", 1, 0, 0, -1, -1, -1, 1);
    sel_req = 1'b0;
    wait_tx("s5", 1'b0);
    sel_req = 1'b1;
    wait_done("s5a");
    chk("s5_idle_gap", int'(busy), 0);
    @(negedge clk27);
    chk("s5_restart", int'(busy), 1);
    chk("s5_restart_blank", int'(blank), 1);
    wait_done("s5b");

    // S6: reset in the middle of a lock wait, then a fresh sequence
    pll_lvl = 1'b0;
    sel_req = 1'b0;
    wait_tx("s6a", 1'b0);
    wait_tx("s6b", 1'b1);
    cyc_n(5);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("s6_abort");
    vs_en = 1'b0; pll_lvl = 1'b1;
    push("s6", 0, 0, 0, VS_TO + RST_CYCLES + 1 + LOCK_STABLE + VS_TO, VS_TO,
         1 + LOCK_STABLE + VS_TO, 0);
    @(negedge clk27);
    reset_n = 1'b1;
    wait_done("s6");

    cyc_n(3);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/output_switch_ctrl.md
OUTPUT_SWITCH_CTRL -- requirements
Module: output_switch_ctrl

Interface
REQ-001 The block SHALL have parameter VS_TO, default 1350000, meaning the vsync-wait timeout in clk27 cycles (50 ms).
REQ-002 The block SHALL have parameter RST_CYCLES, default 27, meaning the HDMI TX reset pulse width in cycles (1 us).
REQ-003 The block SHALL have parameter LOCK_STABLE, default 2700, meaning the cycles pll_lock must stay continuously high (100 us).
REQ-004 The block SHALL have parameter LOCK_TO, default 2700000, meaning the lock-wait timeout in cycles (100 ms).
REQ-005 Port clk27, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port sel_req, input, 1 bit: requested output source, level-sensitive, 1=videogen, 0=scanconverter; already synchronous to clk27.
REQ-008 Port pll_lock, input, 1 bit: scanconverter PLL lock, synchronous to clk27.
REQ-009 Port vsync_in, input, 1 bit: VSYNC of the currently selected output, active-high, synchronous to clk27.
REQ-010 Port src_sel, output, 1 bit: applied output source mux select.
REQ-011 Port blank, output, 1 bit: forces DE and RGB to zero at the output mux.
REQ-012 Port tx_reset_n, output, 1 bit: active-low HDMI transmitter reset.
REQ-013 Port busy, output, 1 bit: high while a switch sequence runs.
REQ-014 Port done, output, 1 bit: one-cycle pulse when a sequence ends.
REQ-015 Port lock_err, output, 1 bit: sticky lock-timeout flag.

Function
REQ-016 The states SHALL be IDLE, BLANK_WAIT, TX_RST, SWITCH, LOCK_WAIT and UNBLANK_WAIT; there SHALL be one shared 22-bit counter, cleared on every state entry.
REQ-017 The vsync edge SHALL be the rising edge of vsync_in, registered once (vs_prev); vs_prev resets to 0.
REQ-018 IDLE: when sel_req != src_sel, the block SHALL latch target=sel_req, set blank=1, busy=1, clear lock_err and enter BLANK_WAIT on the next edge; otherwise it stays in IDLE.
REQ-019 sel_req changes while busy=1 SHALL be ignored; on return to IDLE a still-differing sel_req starts a new sequence on the following cycle.
REQ-020 BLANK_WAIT: on a vsync edge, or when the counter reaches VS_TO-1, the block SHALL enter TX_RST; timeout is not an error.
REQ-021 TX_RST: tx_reset_n SHALL be 0 for exactly RST_CYCLES cycles, then the block SHALL enter SWITCH.
REQ-022 SWITCH (one cycle): the block SHALL set src_sel=target and tx_reset_n=1, then enter LOCK_WAIT if target=0, else UNBLANK_WAIT.
REQ-023 LOCK_WAIT: a stable counter SHALL count cycles with pll_lock=1 and clear to 0 when pll_lock=0; reaching LOCK_STABLE SHALL enter UNBLANK_WAIT.
REQ-024 LOCK_WAIT: if the timeout counter reaches LOCK_TO-1 first, the block SHALL set lock_err=1, pulse done, clear busy and return to IDLE with blank held at 1.
REQ-025 If lock-stable and timeout occur in the same cycle, lock-stable SHALL win.
REQ-026 UNBLANK_WAIT: on a vsync edge, or at VS_TO-1, the block SHALL clear blank and busy, pulse done and return to IDLE.
REQ-027 blank SHALL stay 1 after a lock error until a later sequence completes successfully.
REQ-028 Counters SHALL saturate and never wrap.

Reset
REQ-029 On reset_n=0, asynchronously: state=IDLE, src_sel=1, blank=0, tx_reset_n=1, busy=0, done=0, lock_err=0, all counters=0.
REQ-030 Reset mid-sequence SHALL abort immediately to the reset values; a differing sel_req then starts a fresh sequence after release.

Verification (VS_TO=100, RST_CYCLES=4, LOCK_STABLE=8, LOCK_TO=200)
REQ-031 Scenario 1: after reset, sel_req=0, pll_lock=1, vsync pulse every 50 cycles -> blank=1 next cycle; tx_reset_n low for exactly 4 cycles after the vsync edge; src_sel=0; blank=0 at the next vsync edge after 8 stable cycles; one done pulse.
REQ-032 Scenario 2: while src_sel=0, sel_req=1 -> no LOCK_WAIT; blank=0 at the first vsync edge after SWITCH; lock_err=0.
REQ-033 Scenario 3: vsync_in held 0 -> BLANK_WAIT exits after 100 cycles and UNBLANK_WAIT after 100 cycles; sequence completes with no error.
REQ-034 Scenario 4: sel_req=0 with pll_lock toggling every 5 cycles -> lock_err=1 200 cycles after LOCK_WAIT entry; blank stays 1; busy=0; done pulses once.
REQ-035 Scenario 5: sel_req toggled during TX_RST -> ignored; after done, a second sequence starts the cycle after IDLE is entered.
REQ-036 Scenario 6: reset_n pulsed low during LOCK_WAIT -> outputs at reset values in the same cycle; src_sel=1.
